sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param_if.sv | 34 +++
 rtl/sync_fifo_param.sv | 131 +++++++++++++
 tb/tb_sync_fifo_param.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param: write/read handshake,
// read data, registered handshake results, status flags and occupancy.
// CW must equal $clog2(FIFO_DEPTH+1) of the FIFO it is attached to.
interface sync_fifo_param_if #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
);
    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             wr_ack;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic [CW-1:0]    count;

    // Producer/consumer side.
    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    // FIFO side.
    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary (non power-of-two) depth,
// programmable almost-full/almost-empty levels, occupancy count, and either a
// registered read port (FWFT=0) or first-word-fall-through (FWFT=1).
// Flags are decoded from the count register so they settle right after the
// edge that changed the occupancy; handshake results are registered pulses.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = 7,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

    if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 || AE_LEVEL < 0 ||
        AE_LEVEL >= AF_LEVEL || AF_LEVEL > FIFO_DEPTH ||
        (FWFT != 0 && FWFT != 1)) begin : g_bad_params
        $fatal(1, "sync_fifo_param: illegal parameter combination");
    end

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, wr_ack_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          full;
    logic          empty;
    logic          wr_accept;
    logic          rd_accept;
    logic [FIFO_WIDTH-1:0] head_word;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);

    // Accept decisions and next state of pointers, occupancy and pulses.
    always_comb begin
        wr_accept   = bus.wr_en && !full;
        rd_accept   = bus.rd_en && !empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_accept;
        overflow_d  = bus.wr_en && full;
        underflow_d = bus.rd_en && empty;

        // Explicit wrap keeps non power-of-two depths inside the array.
        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers, occupancy and one-cycle handshake pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign head_word = mem_q[rd_ptr_q];

    if (FWFT == 0) begin : g_reg_read
        logic [FIFO_WIDTH-1:0] dout_q, dout_d;

        assign dout_d = rd_accept ? head_word : dout_q;

        // Registered read port: load the head word on an accepted read, hold otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign bus.data_out = dout_q;
    end else begin : g_fwft_read
        // Head word is presented directly; zero while nothing is stored.
        assign bus.data_out = empty ? '0 : head_word;
    end

    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (count_q >= CNT_AF);
    assign bus.almostempty = (count_q <= CNT_AE);
    assign bus.count       = count_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: instance A (depth 8, registered read) and
// instance B (depth 5, first-word-fall-through). Directed stimulus pushes the
// expected post-edge state into a scoreboard; a monitor on the falling edge
// pops each entry and compares it with the addressed instance.
module tb_sync_fifo_param;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(W), .CW(4)) ifa ();
    sync_fifo_param_if #(.WIDTH(W), .CW(3)) ifb ();

    sync_fifo_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(0)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    sync_fifo_param #(
        .FIFO_WIDTH(W), .FIFO_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    typedef struct {
        int         sel;
        int         id;
        int         cnt;
        logic [W-1:0] dat;
        logic       ack;
        logic       ovf;
        logic       udf;
    } exp_t;

    typedef logic [W-1:0] word_q_t [$];

    exp_t         sb [$];
    word_q_t      mq [2];
    logic [W-1:0] held [2];
    int           n_cmp   = 0;
    int           n_bad   = 0;
    int           step_id = 0;

    function automatic int dep(input int sel);
        return (sel == 0) ? 8 : 5;
    endfunction

    function automatic int afl(input int sel);
        return (sel == 0) ? 7 : 4;
    endfunction

    function automatic bit fw(input int sel);
        return (sel == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string name, input int sel, input int id,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut_%s step %0d: got 0x%0h, required 0x%0h",
                     name, (sel == 0) ? "a" : "b", id, act, req);
        end
    endtask

    // Monitor: compare the addressed instance against the oldest expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] dout, cnt;
        logic        f, em, af, ae, ack, ovf, udf;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                dout = 32'(ifa.data_out); cnt = 32'(ifa.count);
                f = ifa.full; em = ifa.empty; af = ifa.almostfull; ae = ifa.almostempty;
                ack = ifa.wr_ack; ovf = ifa.overflow; udf = ifa.underflow;
            end else begin
                dout = 32'(ifb.data_out); cnt = 32'(ifb.count);
                f = ifb.full; em = ifb.empty; af = ifb.almostfull; ae = ifb.almostempty;
                ack = ifb.wr_ack; ovf = ifb.overflow; udf = ifb.underflow;
            end
            chk("data_out",    e.sel, e.id, dout,       32'(e.dat));
            chk("count",       e.sel, e.id, cnt,        32'(e.cnt));
            chk("full",        e.sel, e.id, 32'(f),     32'(e.cnt == dep(e.sel)));
            chk("empty",       e.sel, e.id, 32'(em),    32'(e.cnt == 0));
            chk("almostfull",  e.sel, e.id, 32'(af),    32'(e.cnt >= afl(e.sel)));
            chk("almostempty", e.sel, e.id, 32'(ae),    32'(e.cnt <= 1));
            chk("wr_ack",      e.sel, e.id, 32'(ack),   32'(e.ack));
            chk("overflow",    e.sel, e.id, 32'(ovf),   32'(e.ovf));
            chk("underflow",   e.sel, e.id, 32'(udf),   32'(e.udf));
        end
    end

    task automatic drive(input int sel, input logic wr, input logic rd, input logic [W-1:0] d);
        ifa.wr_en = 1'b0; ifa.rd_en = 1'b0; ifa.data_in = '0;
        ifb.wr_en = 1'b0; ifb.rd_en = 1'b0; ifb.data_in = '0;
        if (sel == 0) begin
            ifa.wr_en = wr; ifa.rd_en = rd; ifa.data_in = d;
        end else begin
            ifb.wr_en = wr; ifb.rd_en = rd; ifb.data_in = d;
        end
    endtask

    // One clock of stimulus on one instance; expectation comes from a word queue.
    task automatic step(input int sel, input logic wr, input logic rd, input logic [W-1:0] d);
        exp_t e;
        int   n;
        logic wa, ra;
        @(negedge clk);
        drive(sel, wr, rd, d);
        @(posedge clk);
        n  = mq[sel].size();
        wa = wr && (n < dep(sel));
        ra = rd && (n > 0);
        if (ra) held[sel] = mq[sel].pop_front();
        if (wa) mq[sel].push_back(d);
        step_id++;
        e.sel = sel;
        e.id  = step_id;
        e.cnt = mq[sel].size();
        e.ack = wa;
        e.ovf = wr && !wa;
        e.udf = rd && !ra;
        if (fw(sel)) e.dat = (mq[sel].size() > 0) ? mq[sel][0] : '0;
        else         e.dat = held[sel];
        sb.push_back(e);
    endtask

    task automatic reset_checks(input int tag);
        chk("rst_count",       0, tag, 32'(ifa.count),       32'd0);
        chk("rst_empty",       0, tag, 32'(ifa.empty),       32'd1);
        chk("rst_almostempty", 0, tag, 32'(ifa.almostempty), 32'd1);
        chk("rst_full",        0, tag, 32'(ifa.full),        32'd0);
        chk("rst_almostfull",  0, tag, 32'(ifa.almostfull),  32'd0);
        chk("rst_data_out",    0, tag, 32'(ifa.data_out),    32'd0);
        chk("rst_pulses",      0, tag, {29'd0, ifa.wr_ack, ifa.overflow, ifa.underflow}, 32'd0);
        chk("rst_count",       1, tag, 32'(ifb.count),       32'd0);
        chk("rst_empty",       1, tag, 32'(ifb.empty),       32'd1);
        chk("rst_almostempty", 1, tag, 32'(ifb.almostempty), 32'd1);
        chk("rst_full",        1, tag, 32'(ifb.full),        32'd0);
        chk("rst_data_out",    1, tag, 32'(ifb.data_out),    32'd0);
        chk("rst_pulses",      1, tag, {29'd0, ifb.wr_ack, ifb.overflow, ifb.underflow}, 32'd0);
    endtask

    // Mid-cycle reset, checked before any edge; released just after a rising edge.
    task automatic do_reset(input logic hold_wr, input int tag);
        @(negedge clk);
        drive(0, hold_wr, 1'b0, 16'h7777);
        #2 rst = 1'b1;
        #1 reset_checks(tag);
        mq[0].delete();
        mq[1].delete();
        held[0] = '0;
        held[1] = '0;
        repeat (2) @(posedge clk);
        #1 reset_checks(tag + 1);
        #2 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] nb;
        drive(0, 1'b0, 1'b0, '0);
        held[0] = '0;
        held[1] = '0;
        do_reset(1'b0, 1000);

        // Partially fill both instances, then reset mid-operation.
        step(0, 1'b1, 1'b0, 16'hDEAD);
        step(1, 1'b1, 1'b0, 16'hBEEF);
        do_reset(1'b0, 2000);

        // A: nine writes (ninth overflows), nine reads (ninth underflows).
        for (int i = 1; i <= 9; i++) step(0, 1'b1, 1'b0, W'(i));
        for (int i = 1; i <= 9; i++) step(0, 1'b0, 1'b1, '0);

        // A: simultaneous on empty, fill up, simultaneous on full.
        step(0, 1'b1, 1'b1, 16'hABCD);
        for (int i = 0; i < 7; i++) step(0, 1'b1, 1'b0, 16'h0A00 + W'(i));
        step(0, 1'b1, 1'b1, 16'hEEEE);
        step(0, 1'b1, 1'b1, 16'hF00D);

        // A: fill to full, reset with wr_en held, first post-reset word read back.
        step(0, 1'b1, 1'b0, 16'h0B00);
        do_reset(1'b1, 3000);
        step(0, 1'b1, 1'b0, 16'h5555);
        step(0, 1'b0, 1'b1, '0);
        step(0, 1'b0, 1'b1, '0);

        // B: thirteen interleaved ops, occupancy between 1 and 4, wraps at 4->0.
        nb = 16'h0100;
        step(1, 1'b1, 1'b0, nb); nb++;
        step(1, 1'b1, 1'b0, nb); nb++;
        step(1, 1'b1, 1'b0, nb); nb++;
        step(1, 1'b1, 1'b1, nb); nb++;
        step(1, 1'b1, 1'b1, nb); nb++;
        step(1, 1'b0, 1'b1, '0);
        step(1, 1'b1, 1'b0, nb); nb++;
        step(1, 1'b1, 1'b1, nb); nb++;
        step(1, 1'b1, 1'b1, nb); nb++;
        step(1, 1'b1, 1'b0, nb); nb++;
        step(1, 1'b0, 1'b1, '0);
        step(1, 1'b1, 1'b1, nb); nb++;
        step(1, 1'b1, 1'b1, nb); nb++;

        // B: drain past empty, then fill past full.
        for (int i = 0; i < 4; i++) step(1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1'b1, 1'b0, nb);
            nb++;
        end
        step(1, 1'b1, 1'b1, 16'h0FFF);
        for (int i = 0; i < 6; i++) step(1, 1'b0, 1'b1, '0);

        repeat (2) @(negedge clk);
        #1 chk("scoreboard_drained", 0, step_id, 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
